// File: rtl/pic_pkg.sv
// pic_pkg
//   Shared types and constants for the 8259-style control logic:
//   acknowledge-sequencer state type, ICW strobe bit indices and the
//   default level reported for a request that vanished before INTA.
package pic_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PEND  = 3'd1,
    ACK1  = 3'd2,
    WAIT2 = 3'd3,
    ACK2  = 3'd4
  } pic_state_t;

  // Bit positions inside icw_strobe[4:1]
  localparam int ICW1 = 1;
  localparam int ICW2 = 2;
  localparam int ICW3 = 3;
  localparam int ICW4 = 4;

  localparam logic [2:0] SPURIOUS_LVL_DEF = 3'd7;

endpackage

// File: rtl/pic_edge_detect.sv
// pic_edge_detect
//   Registers the clk-synchronous inta_n and reports one-cycle fall/rise
//   pulses by comparing the registered sample with the current value.
// Ports
//   clk     in  system clock
//   rst     in  synchronous active-high reset (sample resets to 1 = idle)
//   inta_n  in  CPU interrupt acknowledge, active low
//   fall    out inta_n went 1 -> 0 this cycle
//   rise    out inta_n went 0 -> 1 this cycle
module pic_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic inta_n,
  output logic fall,
  output logic rise
);

  logic inta_prev;

  always_ff @(posedge clk) begin
    if (rst) inta_prev <= 1'b1;
    else     inta_prev <= inta_n;
  end

  assign fall = inta_prev & ~inta_n;
  assign rise = ~inta_prev & inta_n;

endmodule

// File: rtl/pic_control_logic.sv
// pic_control_logic
//   Holds the ICW configuration captured from the R/W decoder and runs the
//   8086-style two-pulse interrupt acknowledge: raise int_out, mark the ISR
//   bit on the first INTA, drive {vector_base, level} on the second.
// Ports
//   clk, rst               clock / synchronous active-high reset
//   data_in, icw_strobe    ICW byte and one-hot ICW1..ICW4 valid strobes
//   int_req, int_level     pending request and its level from the resolver
//   inta_n                 CPU acknowledge, active low
//   int_out                interrupt request to the CPU
//   data_out, data_oe      vector byte and its bus enable
//   isr_set, auto_eoi      one-cycle ISR set / AEOI clear pulses
//   init_done              ICW sequence complete
//   ltim, sngl, ic4, upm, aeoi, vector_base, icw3   stored configuration
//
// state | meaning
// IDLE  | no request in service; waits for int_req once initialized
// PEND  | int_out asserted, waiting for first INTA fall
// ACK1  | first INTA low, waiting for its rise
// WAIT2 | between pulses, waiting for second INTA fall
// ACK2  | vector on the bus while INTA low; rise ends the cycle
module pic_control_logic
  import pic_pkg::*;
#(
  parameter logic [2:0] SPURIOUS_LVL = SPURIOUS_LVL_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic [4:1] icw_strobe,
  input  logic       int_req,
  input  logic [2:0] int_level,
  input  logic       inta_n,
  output logic       int_out,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic [7:0] isr_set,
  output logic       auto_eoi,
  output logic       init_done,
  output logic       ltim,
  output logic       sngl,
  output logic       ic4,
  output logic       upm,
  output logic       aeoi,
  output logic [4:0] vector_base,
  output logic [7:0] icw3
);

  pic_state_t state;
  logic [2:0] lvl;
  logic       spurious;
  logic       inta_fall;
  logic       inta_rise;
  logic [4:1] icw_win;

  pic_edge_detect u_edge (
    .clk    (clk),
    .rst    (rst),
    .inta_n (inta_n),
    .fall   (inta_fall),
    .rise   (inta_rise)
  );

  // Simultaneous strobes: keep only the lowest-numbered ICW
  always_comb begin
    icw_win = '0;
    if      (icw_strobe[ICW1]) icw_win[ICW1] = 1'b1;
    else if (icw_strobe[ICW2]) icw_win[ICW2] = 1'b1;
    else if (icw_strobe[ICW3]) icw_win[ICW3] = 1'b1;
    else if (icw_strobe[ICW4]) icw_win[ICW4] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lvl         <= '0;
      spurious    <= 1'b0;
      int_out     <= 1'b0;
      data_out    <= '0;
      data_oe     <= 1'b0;
      isr_set     <= '0;
      auto_eoi    <= 1'b0;
      init_done   <= 1'b0;
      ltim        <= 1'b0;
      sngl        <= 1'b0;
      ic4         <= 1'b0;
      upm         <= 1'b0;
      aeoi        <= 1'b0;
      vector_base <= '0;
      icw3        <= '0;
    end else begin
      isr_set  <= '0;
      auto_eoi <= 1'b0;

      if (icw_win[ICW2]) begin
        vector_base <= data_in[7:3];
        if (sngl && !ic4) init_done <= 1'b1;
      end
      if (icw_win[ICW3]) begin
        icw3 <= data_in;
        if (!ic4) init_done <= 1'b1;
      end
      if (icw_win[ICW4]) begin
        upm       <= data_in[0];
        aeoi      <= data_in[1];
        init_done <= 1'b1;
      end

      if (icw_win[ICW1]) begin
        // Re-initialization aborts any acknowledge in flight
        ltim      <= data_in[3];
        sngl      <= data_in[1];
        ic4       <= data_in[0];
        upm       <= 1'b0;
        aeoi      <= 1'b0;
        init_done <= 1'b0;
        state     <= IDLE;
        int_out   <= 1'b0;
        data_oe   <= 1'b0;
        data_out  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (init_done && int_req) begin
              state   <= PEND;
              int_out <= 1'b1;
            end
          end
          PEND: begin
            if (inta_fall) begin
              state    <= ACK1;
              int_out  <= 1'b0;
              lvl      <= int_req ? int_level : SPURIOUS_LVL;
              spurious <= ~int_req;
              if (int_req) isr_set <= 8'd1 << int_level;
            end
          end
          ACK1: begin
            if (inta_rise) state <= WAIT2;
          end
          WAIT2: begin
            if (inta_fall) begin
              state    <= ACK2;
              data_out <= {vector_base, lvl};
              data_oe  <= 1'b1;
            end
          end
          ACK2: begin
            if (inta_rise) begin
              state    <= IDLE;
              data_oe  <= 1'b0;
              data_out <= '0;
              auto_eoi <= aeoi & ~spurious;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pic_control_logic.sv
module tb_pic_control_logic;

  localparam logic [2:0] SPUR = 3'd7;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic [4:1] icw_strobe;
  logic       int_req;
  logic [2:0] int_level;
  logic       inta_n;
  logic       int_out;
  logic [7:0] data_out;
  logic       data_oe;
  logic [7:0] isr_set;
  logic       auto_eoi;
  logic       init_done;
  logic       ltim, sngl, ic4, upm, aeoi;
  logic [4:0] vector_base;
  logic [7:0] icw3;

  int checks = 0;
  int errors = 0;

  // configuration model
  logic       m_ltim, m_sngl, m_ic4, m_upm, m_aeoi, m_init;
  logic [4:0] m_vb;
  logic [7:0] m_icw3;

  always #5 clk = ~clk;

  pic_control_logic dut (
    .clk(clk), .rst(rst), .data_in(data_in), .icw_strobe(icw_strobe),
    .int_req(int_req), .int_level(int_level), .inta_n(inta_n),
    .int_out(int_out), .data_out(data_out), .data_oe(data_oe),
    .isr_set(isr_set), .auto_eoi(auto_eoi), .init_done(init_done),
    .ltim(ltim), .sngl(sngl), .ic4(ic4), .upm(upm), .aeoi(aeoi),
    .vector_base(vector_base), .icw3(icw3)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cfg(input string tag);
    chk({tag, " ltim"},        ltim,        m_ltim);
    chk({tag, " sngl"},        sngl,        m_sngl);
    chk({tag, " ic4"},         ic4,         m_ic4);
    chk({tag, " upm"},         upm,         m_upm);
    chk({tag, " aeoi"},        aeoi,        m_aeoi);
    chk({tag, " init_done"},   init_done,   m_init);
    chk({tag, " vector_base"}, vector_base, m_vb);
    chk({tag, " icw3"},        icw3,        m_icw3);
  endtask

  task automatic model_reset();
    {m_ltim, m_sngl, m_ic4, m_upm, m_aeoi, m_init} = '0;
    m_vb = '0;
    m_icw3 = '0;
  endtask

  // One strobe cycle; the model applies the lowest-numbered ICW only
  task automatic write_icw(input logic [4:1] s, input logic [7:0] d, input string tag);
    icw_strobe = s;
    data_in = d;
    if (s[1]) begin
      m_ltim = d[3]; m_sngl = d[1]; m_ic4 = d[0];
      m_upm = 1'b0; m_aeoi = 1'b0; m_init = 1'b0;
    end else if (s[2]) begin
      m_vb = d[7:3];
      if (m_sngl && !m_ic4) m_init = 1'b1;
    end else if (s[3]) begin
      m_icw3 = d;
      if (!m_ic4) m_init = 1'b1;
    end else if (s[4]) begin
      m_upm = d[0]; m_aeoi = d[1]; m_init = 1'b1;
    end
    tick();
    icw_strobe = '0;
    data_in = $urandom_range(0, 255);
    chk_cfg(tag);
  endtask

  // Whole acknowledge transaction; expectations come from the request alone
  task automatic do_ack(input logic [2:0] level, input bit spur, input string tag);
    logic [7:0] exp_vec, exp_isr, one;
    bit exp_auto;
    int n;
    one      = 8'd1;
    exp_vec  = {m_vb, (spur ? SPUR : level)};
    exp_isr  = spur ? 8'd0 : (one << level);
    exp_auto = m_aeoi && !spur;
    chk({tag, " int_out idle"}, int_out, 1'b0);
    int_req = 1'b1;
    int_level = level;
    tick();
    chk({tag, " int_out raised"}, int_out, 1'b1);
    if (spur) int_req = 1'b0;
    n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++) begin
      tick();
      chk({tag, " int_out held"}, int_out, 1'b1);
      chk({tag, " isr_set quiet"}, isr_set, 8'd0);
    end
    inta_n = 1'b0;
    tick();
    chk({tag, " isr_set first fall"}, isr_set, exp_isr);
    chk({tag, " int_out dropped"}, int_out, 1'b0);
    chk({tag, " data_oe first pulse"}, data_oe, 1'b0);
    int_req = 1'b0;
    int_level = $urandom_range(0, 7);
    tick();
    chk({tag, " isr_set one cycle"}, isr_set, 8'd0);
    inta_n = 1'b1;
    n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++) tick();
    chk({tag, " data_oe between"}, data_oe, 1'b0);
    inta_n = 1'b0;
    tick();
    chk({tag, " data_oe second"}, data_oe, 1'b1);
    chk({tag, " data_out vector"}, data_out, exp_vec);
    chk({tag, " auto_eoi early"}, auto_eoi, 1'b0);
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin
      tick();
      chk({tag, " data_oe hold"}, data_oe, 1'b1);
      chk({tag, " data_out hold"}, data_out, exp_vec);
    end
    inta_n = 1'b1;
    tick();
    chk({tag, " data_oe end"}, data_oe, 1'b0);
    chk({tag, " data_out end"}, data_out, 8'd0);
    chk({tag, " auto_eoi"}, auto_eoi, exp_auto);
    tick();
    chk({tag, " auto_eoi one cycle"}, auto_eoi, 1'b0);
    chk({tag, " int_out after"}, int_out, 1'b0);
  endtask

  initial begin
    logic [7:0] d1, d2, d4;
    rst = 1'b1;
    data_in = '0;
    icw_strobe = '0;
    int_req = 1'b0;
    int_level = '0;
    inta_n = 1'b1;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    chk("reset int_out", int_out, 1'b0);
    chk("reset data_out", data_out, 8'd0);
    chk("reset data_oe", data_oe, 1'b0);
    chk("reset isr_set", isr_set, 8'd0);
    chk("reset auto_eoi", auto_eoi, 1'b0);
    chk_cfg("reset");

    // uninitialized: request must be ignored
    int_req = 1'b1;
    int_level = 3'd2;
    tick(); tick();
    chk("no init int_out", int_out, 1'b0);
    int_req = 1'b0;

    // 1. init, init_done only after ICW4
    write_icw(4'b0001, 8'h13, "init icw1");
    write_icw(4'b0010, 8'h48, "init icw2");
    chk("init_done before icw4", init_done, 1'b0);
    write_icw(4'b1000, 8'h01, "init icw4");
    chk("init_done after icw4", init_done, 1'b1);

    // INTA pulses in IDLE are ignored
    inta_n = 1'b0; tick(); inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    chk("idle inta data_oe", data_oe, 1'b0);
    chk("idle inta isr_set", isr_set, 8'd0);
    inta_n = 1'b1; tick();

    // 2. full acknowledge, level 3
    do_ack(3'd3, 1'b0, "ack lvl3");
    // 3. AEOI, level 5
    write_icw(4'b1000, 8'h03, "aeoi icw4");
    do_ack(3'd5, 1'b0, "aeoi lvl5");
    // 4. spurious
    do_ack(3'd4, 1'b1, "spurious");

    // 5. ICW1 between the two INTA pulses
    int_req = 1'b1; int_level = 3'd1;
    tick();
    chk("abort int_out", int_out, 1'b1);
    inta_n = 1'b0; tick();
    chk("abort isr_set", isr_set, 8'h02);
    int_req = 1'b0;
    inta_n = 1'b1; tick();
    write_icw(4'b0001, 8'h13, "abort icw1");
    chk("abort init_done", init_done, 1'b0);
    chk("abort int_out low", int_out, 1'b0);
    inta_n = 1'b0; tick(); tick();
    chk("abort no data_oe", data_oe, 1'b0);
    chk("abort no data_out", data_out, 8'd0);
    inta_n = 1'b1;
    int_req = 1'b1; int_level = 3'd6;
    tick(); tick(); tick();
    chk("abort req ignored", int_out, 1'b0);
    int_req = 1'b0;
    tick();

    // single mode without ICW4; simultaneous ICW2+ICW3 strobes, ICW2 wins
    write_icw(4'b0001, 8'h1A, "sngl icw1");
    write_icw(4'b0110, 8'h50, "multi strobe");
    chk("multi strobe init_done", init_done, 1'b1);
    do_ack(3'd0, 1'b0, "sngl lvl0");

    // cascade without ICW4: ICW3 completes init
    write_icw(4'b0001, 8'h10, "casc icw1");
    write_icw(4'b0010, 8'h48, "casc icw2");
    chk("casc init pending", init_done, 1'b0);
    write_icw(4'b0100, 8'hA5, "casc icw3");
    do_ack(3'd7, 1'b0, "casc lvl7");

    // randomized initialization plus acknowledge transactions
    for (int k = 0; k < 20; k++) begin
      d1 = 8'($urandom_range(0, 255));
      d1[0] = 1'b1;
      d2 = 8'($urandom_range(0, 255));
      d4 = 8'($urandom_range(0, 255));
      write_icw(4'b0001, d1, "rnd icw1");
      write_icw(4'b0010, d2, "rnd icw2");
      if (!d1[1]) write_icw(4'b0100, 8'($urandom_range(0, 255)), "rnd icw3");
      write_icw(4'b1000, d4, "rnd icw4");
      for (int j = 0; j < 3; j++)
        do_ack(3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0), "rnd ack");
    end

    // 6. reset during ACK2
    int_req = 1'b1; int_level = 3'd2;
    tick();
    inta_n = 1'b0; tick();
    int_req = 1'b0;
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    chk("rst pre data_oe", data_oe, 1'b1);
    rst = 1'b1;
    inta_n = 1'b1;
    model_reset();
    tick();
    rst = 1'b0;
    chk("rst ack2 int_out", int_out, 1'b0);
    chk("rst ack2 data_out", data_out, 8'd0);
    chk("rst ack2 data_oe", data_oe, 1'b0);
    chk("rst ack2 isr_set", isr_set, 8'd0);
    chk("rst ack2 auto_eoi", auto_eoi, 1'b0);
    chk_cfg("rst ack2");
    tick();
    chk("rst ack2 idle data_oe", data_oe, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
